mem_access_unit: RTL

- MEM-stage load/store engine.
- Consumes the EX/MEM register outputs: address on alu_data_mem, store data on rs2_data_mem, plus load_mem, store_mem and funct3.
- Drives a req/ack data-memory bus and stalls the pipeline while an access is outstanding.
- Delivers sign/zero-extended load data toward the MEM/WB register.

---
 rtl/mem_pkg.sv | 18 +
 rtl/lsu_align.sv | 73 +++++++
 rtl/mem_access_unit.sv | 170 +++++++++++++++++
 3 files changed

// File: rtl/mem_pkg.sv
// Shared encodings for the MEM-stage load/store engine.
package mem_pkg;

    localparam logic [2:0] F3_LB  = 3'd0;
    localparam logic [2:0] F3_LH  = 3'd1;
    localparam logic [2:0] F3_LW  = 3'd2;
    localparam logic [2:0] F3_LBU = 3'd4;
    localparam logic [2:0] F3_LHU = 3'd5;
    localparam logic [2:0] F3_SB  = 3'd0;
    localparam logic [2:0] F3_SH  = 3'd1;
    localparam logic [2:0] F3_SW  = 3'd2;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_e;

endpackage

// File: rtl/lsu_align.sv
// Combinational lane logic: store replication/strobes, load extraction/extension,
// and misalignment detection.
module lsu_align
    import mem_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [2:0]      req_funct3,
    input  logic [1:0]      req_addr_lo,
    input  logic            req_store,
    input  logic [XLEN-1:0] req_rs2,
    output logic [XLEN-1:0] req_wdata,
    output logic [3:0]      req_wstrb,
    output logic            req_misaligned,
    input  logic [2:0]      rsp_funct3,
    input  logic [1:0]      rsp_addr_lo,
    input  logic [XLEN-1:0] rsp_rdata,
    output logic [XLEN-1:0] rsp_data
);

    logic [7:0]  rd_byte [4];
    logic [7:0]  sel_byte;
    logic [15:0] sel_half;

    for (genvar gi = 0; gi < 4; gi++) begin : g_lane
        assign rd_byte[gi] = rsp_rdata[8*gi +: 8];
    end

    // Halfword and word codes are shared between loads and stores.
    always_comb begin
        req_misaligned = 1'b0;
        case (req_funct3)
            F3_LH, F3_LHU: req_misaligned = req_addr_lo[0];
            F3_LW:         req_misaligned = (req_addr_lo != 2'b00);
            default:       req_misaligned = 1'b0;
        endcase
    end

    always_comb begin
        req_wdata = req_rs2;
        req_wstrb = 4'b0000;
        case (req_funct3)
            F3_SB: begin
                req_wdata = {(XLEN/8){req_rs2[7:0]}};
                req_wstrb = 4'b0001 << req_addr_lo;
            end
            F3_SH: begin
                req_wdata = {(XLEN/16){req_rs2[15:0]}};
                req_wstrb = req_addr_lo[1] ? 4'b1100 : 4'b0011;
            end
            default: begin
                req_wdata = req_rs2;
                req_wstrb = 4'b1111;
            end
        endcase
        if (!req_store) begin
            req_wstrb = 4'b0000;
        end
    end

    always_comb begin
        sel_byte = rd_byte[rsp_addr_lo];
        sel_half = rsp_addr_lo[1] ? {rd_byte[3], rd_byte[2]} : {rd_byte[1], rd_byte[0]};
        case (rsp_funct3)
            F3_LB:   rsp_data = {{(XLEN-8){sel_byte[7]}}, sel_byte};
            F3_LH:   rsp_data = {{(XLEN-16){sel_half[15]}}, sel_half};
            F3_LBU:  rsp_data = {{(XLEN-8){1'b0}}, sel_byte};
            F3_LHU:  rsp_data = {{(XLEN-16){1'b0}}, sel_half};
            default: rsp_data = rsp_rdata;
        endcase
    end

endmodule

// File: rtl/mem_access_unit.sv
// MEM-stage load/store engine: issues one req/ack bus access per instruction,
// stalls the pipeline while it is outstanding, and times out silent slaves.
module mem_access_unit
    import mem_pkg::*;
#(
    parameter int XLEN           = 32,
    parameter int TIMEOUT_CYCLES = 16,
    parameter int CNT_W          = $clog2(TIMEOUT_CYCLES + 1)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            valid_mem,
    input  logic            load_mem,
    input  logic            store_mem,
    input  logic [2:0]      funct3_mem,
    input  logic [XLEN-1:0] alu_data_mem,
    input  logic [XLEN-1:0] rs2_data_mem,
    output logic            dmem_req,
    output logic            dmem_we,
    output logic [XLEN-1:0] dmem_addr,
    output logic [XLEN-1:0] dmem_wdata,
    output logic [3:0]      dmem_wstrb,
    input  logic [XLEN-1:0] dmem_rdata,
    input  logic            dmem_ack,
    output logic            stall_mem,
    output logic [XLEN-1:0] load_data_wb,
    output logic            load_valid_wb,
    output logic            misaligned_o,
    output logic            bus_err_o
);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             req_q, req_d;
    logic             we_q, we_d;
    logic [XLEN-1:0]  addr_q, addr_d;
    logic [XLEN-1:0]  wdata_q, wdata_d;
    logic [3:0]       wstrb_q, wstrb_d;
    logic [2:0]       f3_q, f3_d;
    logic [1:0]       lo_q, lo_d;
    logic [XLEN-1:0]  load_data_q, load_data_d;
    logic             load_valid_q, load_valid_d;
    logic             mis_q, mis_d;
    logic             bus_err_q, bus_err_d;

    logic            access, is_store, misaligned, go, timeout;
    logic [XLEN-1:0] fmt_wdata, fmt_load;
    logic [3:0]      fmt_wstrb;

    // A load wins when both load and store are flagged.
    assign access   = valid_mem & (load_mem | store_mem);
    assign is_store = store_mem & ~load_mem;
    assign go       = (state_q == IDLE) & access & ~misaligned;
    assign timeout  = (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));

    lsu_align #(.XLEN(XLEN)) u_align (
        .req_funct3     (funct3_mem),
        .req_addr_lo    (alu_data_mem[1:0]),
        .req_store      (is_store),
        .req_rs2        (rs2_data_mem),
        .req_wdata      (fmt_wdata),
        .req_wstrb      (fmt_wstrb),
        .req_misaligned (misaligned),
        .rsp_funct3     (f3_q),
        .rsp_addr_lo    (lo_q),
        .rsp_rdata      (dmem_rdata),
        .rsp_data       (fmt_load)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            req_q        <= 1'b0;
            we_q         <= 1'b0;
            addr_q       <= '0;
            wdata_q      <= '0;
            wstrb_q      <= '0;
            f3_q         <= '0;
            lo_q         <= '0;
            load_data_q  <= '0;
            load_valid_q <= 1'b0;
            mis_q        <= 1'b0;
            bus_err_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            req_q        <= req_d;
            we_q         <= we_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            wstrb_q      <= wstrb_d;
            f3_q         <= f3_d;
            lo_q         <= lo_d;
            load_data_q  <= load_data_d;
            load_valid_q <= load_valid_d;
            mis_q        <= mis_d;
            bus_err_q    <= bus_err_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (go) state_d = BUSY;
            BUSY:    if (dmem_ack || timeout) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Stall drops in the ack/timeout cycle so EX/MEM advances at that edge.
    always_comb begin
        stall_mem = 1'b0;
        case (state_q)
            IDLE:    stall_mem = go;
            BUSY:    stall_mem = ~dmem_ack & ~timeout;
            default: stall_mem = 1'b0;
        endcase
    end

    always_comb begin
        cnt_d        = '0;
        req_d        = req_q;
        we_d         = we_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        wstrb_d      = wstrb_q;
        f3_d         = f3_q;
        lo_d         = lo_q;
        load_data_d  = load_data_q;
        load_valid_d = 1'b0;
        mis_d        = 1'b0;
        bus_err_d    = 1'b0;
        if (state_q == IDLE) begin
            mis_d = access & misaligned;
            if (go) begin
                req_d   = 1'b1;
                we_d    = is_store;
                addr_d  = {alu_data_mem[XLEN-1:2], 2'b00};
                wdata_d = fmt_wdata;
                wstrb_d = fmt_wstrb;
                f3_d    = funct3_mem;
                lo_d    = alu_data_mem[1:0];
            end
        end else begin
            cnt_d = cnt_q + CNT_W'(1);
            if (dmem_ack) begin
                req_d        = 1'b0;
                load_valid_d = ~we_q;
                if (!we_q) begin
                    load_data_d = fmt_load;
                end
            end else if (timeout) begin
                req_d     = 1'b0;
                bus_err_d = 1'b1;
            end
        end
    end

    assign dmem_req      = req_q;
    assign dmem_we       = we_q;
    assign dmem_addr     = addr_q;
    assign dmem_wdata    = wdata_q;
    assign dmem_wstrb    = wstrb_q;
    assign load_data_wb  = load_data_q;
    assign load_valid_wb = load_valid_q;
    assign misaligned_o  = mis_q;
    assign bus_err_o     = bus_err_q;

endmodule
